// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry and MRET return sequencer.
// Latches the committing trap, writes mepc/mcause/mtval, swaps MIE/MPIE,
// stalls and flushes the pipeline, then redirects fetch to mtvec or mepc.
// Optional macro TRAP_VECTORED_EN enables vectored interrupt targets
// (base + 4*cause when mtvec mode is 01); otherwise direct mode only.
module trap_controller #(
  parameter int         XLEN            = 32,
  parameter logic [1:0] MTVEC_MODE_MASK = 2'b11
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_InstructionValid,
  input  logic            i_ExceptionRaised,
  input  logic            i_Interrupt,
  input  logic [3:0]      i_ExceptionCause,
  input  logic            i_Mret,
  input  logic [XLEN-1:0] i_TrapPC,
  input  logic [XLEN-1:0] i_TrapValue,
  input  logic [XLEN-1:0] i_Mtvec,
  input  logic            i_CsrWrite,
  input  logic [11:0]     i_CsrAddress,
  input  logic [XLEN-1:0] i_CsrWriteData,
  output logic            o_Stall,
  output logic            o_Flush,
  output logic            o_PCRedirect,
  output logic [XLEN-1:0] o_RedirectPC,
  output logic [XLEN-1:0] o_Mepc,
  output logic [XLEN-1:0] o_Mcause,
  output logic [XLEN-1:0] o_Mtval,
  output logic [XLEN-1:0] o_Mstatus,
  output logic            o_InterruptEnable
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE     = 3'd1,
    STATUS   = 3'd2,
    REDIRECT = 3'd3,
    RESTORE  = 3'd4
  } trapState_t;

  trapState_t stateReg, stateNext;

  // Request qualification, evaluated only while idle
  logic trapAccept;
  logic mretAccept;
  logic csrWriteEn;

  // Trap context captured on the accept cycle
  logic [3:0]      causeReg;
  logic            interruptReg;
  logic            mretReg;
  logic [XLEN-1:2] trapPcReg;
  logic [XLEN-1:0] trapValueReg;

  // Architectural trap CSRs
  logic [XLEN-1:0] mepcReg;
  logic [XLEN-1:0] mcauseReg;
  logic [XLEN-1:0] mtvalReg;
  logic            mieReg;
  logic            mpieReg;

  logic [XLEN-1:0] trapTarget;

  // Bits that only matter in some builds (mode bits) or are dropped by alignment
  logic unusedBits;
  assign unusedBits = ^{i_Mtvec[1:0] & MTVEC_MODE_MASK, i_TrapPC[1:0]};

  // Interrupts are masked by MIE; exceptions always trap. An exception
  // shadows a simultaneous MRET, and any accept swallows a CSR write.
  assign trapAccept = (stateReg == IDLE) & i_InstructionValid & i_ExceptionRaised
                      & (~i_Interrupt | mieReg);
  assign mretAccept = (stateReg == IDLE) & i_InstructionValid & i_Mret & ~i_ExceptionRaised;
  assign csrWriteEn = (stateReg == IDLE) & i_CsrWrite & ~trapAccept & ~mretAccept;

  // Handler address: aligned mtvec base, optionally offset by cause for interrupts
  always_comb begin
    trapTarget = {i_Mtvec[XLEN-1:2], 2'b00};
`ifdef TRAP_VECTORED_EN
    if (((i_Mtvec[1:0] & MTVEC_MODE_MASK) == 2'b01) && interruptReg) begin
      trapTarget = {i_Mtvec[XLEN-1:2], 2'b00} + {{(XLEN-6){1'b0}}, causeReg, 2'b00};
    end
`endif
  end

  // State register; reset aborts any sequence in flight
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and pipeline control outputs
  always_comb begin
    stateNext    = stateReg;
    o_Stall      = 1'b1;
    o_Flush      = 1'b0;
    o_PCRedirect = 1'b0;
    o_RedirectPC = '0;
    case (stateReg)
      IDLE: begin
        o_Stall = 1'b0;
        if (trapAccept) begin
          o_Flush   = 1'b1;
          stateNext = SAVE;
        end else if (mretAccept) begin
          stateNext = RESTORE;
        end
      end
      SAVE:    stateNext = STATUS;
      STATUS:  stateNext = REDIRECT;
      RESTORE: stateNext = REDIRECT;
      REDIRECT: begin
        o_PCRedirect = 1'b1;
        o_RedirectPC = mretReg ? mepcReg : trapTarget;
        stateNext    = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture trap context once, on the accept cycle only
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      causeReg     <= '0;
      interruptReg <= 1'b0;
      mretReg      <= 1'b0;
      trapPcReg    <= '0;
      trapValueReg <= '0;
    end else if (trapAccept) begin
      causeReg     <= i_ExceptionCause;
      interruptReg <= i_Interrupt;
      mretReg      <= 1'b0;
      trapPcReg    <= i_TrapPC[XLEN-1:2];
      trapValueReg <= i_TrapValue;
    end else if (mretAccept) begin
      mretReg <= 1'b1;
    end
  end

  // CSR updates: sequencer writes in SAVE/STATUS/RESTORE, software writes when idle
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      mepcReg   <= '0;
      mcauseReg <= '0;
      mtvalReg  <= '0;
      mieReg    <= 1'b0;
      mpieReg   <= 1'b0;
    end else begin
      case (stateReg)
        SAVE: begin
          mepcReg   <= {trapPcReg, 2'b00};
          mcauseReg <= {interruptReg, {(XLEN-5){1'b0}}, causeReg};
          mtvalReg  <= interruptReg ? '0 : trapValueReg;
        end
        STATUS: begin
          mpieReg <= mieReg;
          mieReg  <= 1'b0;
        end
        RESTORE: begin
          mieReg  <= mpieReg;
          mpieReg <= 1'b1;
        end
        IDLE: begin
          if (csrWriteEn) begin
            case (i_CsrAddress)
              CSR_MSTATUS: begin
                mieReg  <= i_CsrWriteData[3];
                mpieReg <= i_CsrWriteData[7];
              end
              CSR_MEPC:   mepcReg   <= {i_CsrWriteData[XLEN-1:2], 2'b00};
              CSR_MCAUSE: mcauseReg <= i_CsrWriteData;
              CSR_MTVAL:  mtvalReg  <= i_CsrWriteData;
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  assign o_Mepc            = mepcReg;
  assign o_Mcause          = mcauseReg;
  assign o_Mtval           = mtvalReg;
  // MPP is hardwired to machine mode
  assign o_Mstatus         = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, mpieReg, 3'b000, mieReg, 3'b000};
  assign o_InterruptEnable = mieReg;

endmodule
